// File: rtl/pkg_system_mdr.sv
// pkg_system_mdr: shared types and constants for the MDR result path
package pkg_system_mdr;
  localparam int DW_BCD = 16;
  localparam int ND_BCD = 5;
  localparam int CW_BCD = $clog2(DW_BCD + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  typedef struct packed {
    logic [DW_BCD-1:0] mag;
    logic [4*ND_BCD-1:0] bcd;
    logic [CW_BCD-1:0] cnt;
  } bcd_work_t;
endpackage

// File: rtl/add_con.sv
// add_con: double-dabble digit adjust, adds 3 to any digit above 4
module add_con (
  input  logic [3:0] a,
  output logic [3:0] y
);
  assign y = a > 4'd4 ? a + 4'd3 : a;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: signed binary to sign+BCD converter, one double-dabble step per clock
module bin_to_bcd_seq
  import pkg_system_mdr::*;
#(
  parameter int DW = DW_BCD,
  parameter int ND = ND_BCD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [DW-1:0]   i_data,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_sign,
  output logic [4*ND-1:0] o_bcd
);
  localparam int CW = $clog2(DW + 1);
  bcd_state_t state_q, state_d;
  bcd_work_t work_q, work_d;
  logic neg_q, neg_d, sign_d;
  logic [4*ND-1:0] adj, bcd_d;
  logic [DW-1:0] mag;
  assign mag = i_data[DW-1] ? -i_data : i_data;
  for (genvar d = 0; d < ND; d++) begin : g_dig
    add_con u_add (.a(work_q.bcd[4*d +: 4]), .y(adj[4*d +: 4]));
  end
  assign o_busy = state_q != IDLE;
  assign o_done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    neg_d = neg_q;
    bcd_d = o_bcd;
    sign_d = o_sign;
    case (state_q)
      IDLE: if (i_start) begin
        work_d.mag = mag;
        work_d.bcd = '0;
        work_d.cnt = '0;
        neg_d = i_data[DW-1];
        state_d = SHIFT;
      end
      SHIFT: begin
        work_d.bcd = {adj[4*ND-2:0], work_q.mag[DW-1]};
        work_d.mag = work_q.mag << 1;
        work_d.cnt = work_q.cnt + 1'b1;
        if (work_q.cnt == CW'(DW - 1)) begin
          bcd_d = work_d.bcd;
          sign_d = neg_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      work_q <= '0;
      neg_q <= 1'b0;
      o_bcd <= '0;
      o_sign <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      neg_q <= neg_d;
      o_bcd <= bcd_d;
      o_sign <= sign_d;
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and random checks of bin_to_bcd_seq against a decimal model
module tb_bin_to_bcd_seq;
  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0;
  logic [15:0] i_data = '0;
  logic o_busy, o_done, o_sign;
  logic [19:0] o_bcd;
  int vectors = 0, miscompares = 0;
  bin_to_bcd_seq dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data),
    .o_busy(o_busy), .o_done(o_done), .o_sign(o_sign), .o_bcd(o_bcd)
  );
  always #5 clk = ~clk;
  function automatic logic [20:0] model(input logic [15:0] d);
    int m;
    logic [19:0] r;
    m = d[15] ? 65536 - int'(d) : int'(d);
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {d[15], r};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [15:0] d, input bit glitch, input bit scramble);
    int n, busy;
    logic [20:0] exp;
    exp = model(d);
    i_start = 1'b1;
    i_data = d;
    tick();
    i_start = 1'b0;
    busy = 0;
    for (n = 0; n < 40; n++) begin
      if (o_busy) busy++;
      if (o_done) break;
      i_start = glitch && n == 4;
      if (glitch && n == 4) i_data = 16'h1234;
      if (scramble) i_data = 16'($urandom);
      tick();
    end
    check("done_latency", n, 16);
    check("busy_cycles", busy, 17);
    check("bcd", o_bcd, exp[19:0]);
    check("sign", o_sign, exp[20]);
    i_start = glitch;
    i_data = 16'h1234;
    tick();
    i_start = 1'b0;
    check("idle_after_done", {o_busy, o_done}, 0);
    check("bcd_hold", o_bcd, exp[19:0]);
  endtask
  initial begin
    #1;
    check("rst_outputs", {o_busy, o_done, o_sign, o_bcd}, 0);
    tick();
    rst = 1'b0;
    tick();
    run(16'h0000, 0, 0);
    run(16'h3039, 0, 0);
    run(16'h7FFF, 0, 0);
    run(16'h8000, 0, 0);
    run(16'hFFFF, 0, 0);
    run(16'h0063, 1, 0);
    tick();
    check("no_queued_start", {o_busy, o_done}, 0);
    run(16'h1234, 0, 0);
    run(16'h0400, 0, 1);
    i_start = 1'b1;
    i_data = 16'h3039;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("busy_before_abort", o_busy, 1);
    rst = 1'b1;
    #1;
    check("abort_outputs", {o_busy, o_done, o_sign, o_bcd}, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_done_after_abort", o_done, 0);
    end
    run(16'h000A, 0, 0);
    for (int i = 0; i < 25; i++) run(16'($urandom), 0, i % 3 == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
